uart_rx_frame_sampler: RTL and testbench

Parametrised UART receive front end. It synchronises the raw RX pin, detects the start-bit falling edge in IDLE, and majority-votes three oversampled points at each bit centre. It deserialises DATA_BITS LSB-first and checks stop and (optionally) parity. It sits between the baud-rate tick generator and the RX FIFO/controller, and supersedes the single-purpose RX synchroniser.

---
 rtl/uart_rx_pkg.sv | 26 ++
 rtl/uart_rx_frame_sampler_if.sv | 22 ++
 rtl/rx_input_sync.sv | 53 +++++
 rtl/uart_rx_frame_sampler.sv | 204 ++++++++++++++++++++
 tb/tb_uart_rx_frame_sampler.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_pkg.sv
// ---------------------------------------------------------------------------
// uart_rx_pkg
// Shared definitions for the UART receive frame sampler:
//   - rx_state_e : one-hot style FSM encodings (IDLE is all zeros)
//   - vote3      : majority of three samples
//   - cnt_width  : width of the oversample tick counter
// ---------------------------------------------------------------------------
package uart_rx_pkg;

   typedef enum logic [4:0] {
      IDLE   = 5'b0_0000,
      START  = 5'b0_0001,
      DATA   = 5'b0_0010,
      PARITY = 5'b0_0100,
      STOP   = 5'b0_1000
   } rx_state_e;

   function automatic logic vote3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   function automatic int cnt_width(input int oversample);
      return $clog2(oversample);
   endfunction

endpackage

// File: rtl/uart_rx_frame_sampler_if.sv
// ---------------------------------------------------------------------------
// uart_rx_frame_sampler_if
// Received-frame bundle from the sampler to the RX FIFO/controller.
//   Data_o      : last received word, LSB = first data bit
//   DataValid_o : one-clk pulse, frame complete
//   FrameErr_o  : stop bit voted 0, qualified by DataValid_o
//   ParityErr_o : parity mismatch, qualified by DataValid_o
// Handshake: DataValid_o is a single-cycle strobe with no back-pressure; the
// three payload signals are stable from the strobe until the next strobe.
// Modports: master = sampler (drives), slave = consumer (reads).
// ---------------------------------------------------------------------------
interface uart_rx_frame_sampler_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] Data_o;
   logic                 DataValid_o;
   logic                 FrameErr_o;
   logic                 ParityErr_o;

   modport master (output Data_o, output DataValid_o, output FrameErr_o, output ParityErr_o);
   modport slave  (input  Data_o, input  DataValid_o, input  FrameErr_o, input  ParityErr_o);
endinterface

// File: rtl/rx_input_sync.sv
// ---------------------------------------------------------------------------
// rx_input_sync
// RX pin synchroniser, falling-edge detector and three-point vote capture.
// Everything advances only on the oversample tick (acq).
//   rx      : raw RX pin
//   acq     : oversample tick
//   cap_lo  : capture the first vote sample on this tick
//   cap_mid : capture the second vote sample on this tick
//   fall    : tick-qualified falling edge entering the last sync stage
//   vote    : majority of the two captured samples and the current sample
// ---------------------------------------------------------------------------
module rx_input_sync
   import uart_rx_pkg::*;
#(
   parameter int SYNC_STAGES = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic rx,
   input  logic acq,
   input  logic cap_lo,
   input  logic cap_mid,
   output logic fall,
   output logic vote
);

   // Resets to all ones so releasing reset never looks like a start edge.
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s_lo_q;
   logic                   s_mid_q;
   logic                   sample;

   assign sample = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q  <= '1;
         s_lo_q  <= 1'b1;
         s_mid_q <= 1'b1;
      end else if (acq) begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
         if (cap_lo)  s_lo_q  <= sample;
         if (cap_mid) s_mid_q <= sample;
      end
   end

   // Previous sample (last stage) is 1 and the newest one (about to replace
   // it) is 0. Detecting one stage early lets the first start-bit sample sit
   // in the last stage while cnt reads 0, so cnt = k always means sample k.
   assign fall = acq & sample & ~sync_q[SYNC_STAGES-2];
   assign vote = vote3(s_lo_q, s_mid_q, sample);

endmodule

// File: rtl/uart_rx_frame_sampler.sv
// ---------------------------------------------------------------------------
// uart_rx_frame_sampler
// UART receive front end: synchronise RX, detect the start edge, majority
// vote each bit centre, deserialise LSB-first, check stop and parity.
// Optional parity check: define RX_PARITY_CHECK_EN.
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   Rx_i       : raw RX pin (idle high)
//   AcqSig_i   : oversample tick, OVERSAMPLE per bit
//   Enable_i   : receiver enable; low forces IDLE
//   frame      : received word / valid strobe / error flags (master)
//   State_o    : FSM state for debug and neighbouring controllers
//   Rx_Synch_o : one-clk pulse when a start edge is accepted
// ---------------------------------------------------------------------------
module uart_rx_frame_sampler
   import uart_rx_pkg::*;
#(
   parameter int DATA_BITS   = 8,
   parameter int OVERSAMPLE  = 16,
   parameter int SYNC_STAGES = 3,
   parameter int PARITY_ODD  = 0
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           Rx_i,
   input  logic                           AcqSig_i,
   input  logic                           Enable_i,
   uart_rx_frame_sampler_if.master        frame,
   output logic [4:0]                     State_o,
   output logic                           Rx_Synch_o
);

   localparam int CW = cnt_width(OVERSAMPLE);
   localparam int M  = OVERSAMPLE / 2;
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [CW-1:0] CNT_LO   = CW'(M - 1);
   localparam logic [CW-1:0] CNT_MID  = CW'(M);
   localparam logic [CW-1:0] CNT_HI   = CW'(M + 1);
   localparam logic [CW-1:0] CNT_TOP  = CW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("DATA_BITS must be 5..9");
   end
   if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
      $error("OVERSAMPLE must be even and at least 4");
   end
   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("SYNC_STAGES must be at least 2");
   end
   if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity
      $error("PARITY_ODD must be 0 or 1");
   end

   rx_state_e            state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 ferr_q, ferr_d;
   logic                 synch_q, synch_d;
   logic                 fall, vote, vote_tick;
`ifdef RX_PARITY_CHECK_EN
   logic                 perr_q, perr_d;
   logic                 perr_pend_q, perr_pend_d;
`endif

   rx_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk     (clk),
      .rst     (rst),
      .rx      (Rx_i),
      .acq     (AcqSig_i),
      .cap_lo  (cnt_q == CNT_LO),
      .cap_mid (cnt_q == CNT_MID),
      .fall    (fall),
      .vote    (vote)
   );

   assign vote_tick = (cnt_q == CNT_HI);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = ferr_q;
      synch_d = 1'b0;
`ifdef RX_PARITY_CHECK_EN
      perr_d      = perr_q;
      perr_pend_d = perr_pend_q;
`endif
      // Enable has priority over everything, including a stop vote.
      if (!Enable_i) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else if (AcqSig_i) begin
         cnt_d = (cnt_q == CNT_TOP) ? '0 : cnt_q + 1'b1;
         unique case (state_q)
            IDLE: begin
               cnt_d = '0;
               if (fall) begin
                  synch_d = 1'b1;
                  state_d = START;
               end
            end
            START: begin
               if (vote_tick) begin
                  if (vote) begin
                     state_d = IDLE;
                  end else begin
                     state_d = DATA;
                     bit_d   = '0;
                  end
               end
            end
            // bit_q counts votes taken; the tick counter keeps running
            // across bit boundaries so each vote lands on the next centre.
            DATA: begin
               if (vote_tick) begin
                  shift_d = {vote, shift_q[DATA_BITS-1:1]};
                  if (bit_q == BIT_LAST) begin
`ifdef RX_PARITY_CHECK_EN
                     state_d = PARITY;
`else
                     state_d = STOP;
`endif
                  end else begin
                     bit_d = bit_q + 1'b1;
                  end
               end
            end
`ifdef RX_PARITY_CHECK_EN
            PARITY: begin
               if (vote_tick) begin
                  perr_pend_d = ((^shift_q) ^ vote) != 1'(PARITY_ODD);
                  state_d     = STOP;
               end
            end
`endif
            // Return to IDLE right at the stop vote so a back-to-back start
            // edge in the second half of the stop bit is not missed.
            STOP: begin
               if (vote_tick) begin
                  data_d  = shift_q;
                  ferr_d  = ~vote;
                  valid_d = 1'b1;
`ifdef RX_PARITY_CHECK_EN
                  perr_d  = perr_pend_q;
`endif
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         synch_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
         synch_q <= synch_d;
      end
   end

`ifdef RX_PARITY_CHECK_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perr_q      <= 1'b0;
         perr_pend_q <= 1'b0;
      end else begin
         perr_q      <= perr_d;
         perr_pend_q <= perr_pend_d;
      end
   end
   assign frame.ParityErr_o = perr_q;
`else
   assign frame.ParityErr_o = 1'b0;
`endif

   assign frame.Data_o      = data_q;
   assign frame.DataValid_o = valid_q;
   assign frame.FrameErr_o  = ferr_q;
   assign State_o           = state_q;
   assign Rx_Synch_o        = synch_q;

endmodule

// File: tb/tb_uart_rx_frame_sampler.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_frame_sampler
// Drives UART frames tick by tick (one AcqSig_i pulse every second clk) and
// compares received words against a table of known frames and against a
// waveform-level majority model for randomised noisy frames.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx_frame_sampler;

   localparam int DATA_BITS   = 8;
   localparam int OVERSAMPLE  = 16;
   localparam int SYNC_STAGES = 3;
   localparam int PARITY_ODD  = 0;
   localparam int M           = OVERSAMPLE / 2;
`ifdef RX_PARITY_CHECK_EN
   localparam int PAR_BITS = 1;
`else
   localparam int PAR_BITS = 0;
`endif
   localparam int NB = 1 + DATA_BITS + PAR_BITS + 1;
   localparam int W  = DATA_BITS + 2;               // {perr, ferr, data}
   localparam int VOTE_OFS = (NB - 1) * OVERSAMPLE + M + 2;
   localparam logic [4:0] ST_IDLE = 5'b0_0000;
   localparam logic [4:0] ST_DATA = 5'b0_0010;

   // ---------------- clock / reset / DUT ----------------
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       Rx_i = 1'b1;
   logic       AcqSig_i = 1'b0;
   logic       Enable_i = 1'b0;
   logic [4:0] State_o;
   logic       Rx_Synch_o;

   always #5 clk = ~clk;

   uart_rx_frame_sampler_if #(.DATA_BITS(DATA_BITS)) frame ();

   uart_rx_frame_sampler #(
      .DATA_BITS(DATA_BITS), .OVERSAMPLE(OVERSAMPLE),
      .SYNC_STAGES(SYNC_STAGES), .PARITY_ODD(PARITY_ODD)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .Rx_i       (Rx_i),
      .AcqSig_i   (AcqSig_i),
      .Enable_i   (Enable_i),
      .frame      (frame),
      .State_o    (State_o),
      .Rx_Synch_o (Rx_Synch_o)
   );

   // ---------------- bookkeeping ----------------
   int errors = 0;
   int checks = 0;
   int tick_no = 0;
   int synch_cnt = 0;
   int synch_tick = -1;
   bit drop_armed = 1'b0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] got_q[$];
   logic wave[$];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Monitor: samples on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (frame.DataValid_o)
         got_q.push_back({frame.ParityErr_o, frame.FrameErr_o, frame.Data_o});
      if (Rx_Synch_o) begin
         synch_cnt++;
         synch_tick = tick_no;
      end
   end

   // ---------------- driver tasks ----------------
   // One oversample tick: AcqSig_i high for one clk, low for the next.
   task automatic tick(input logic v);
      @(negedge clk);
      Rx_i = v;
      AcqSig_i = 1'b1;
      tick_no++;
      if (drop_armed && synch_tick >= 0 && tick_no == synch_tick + VOTE_OFS)
         Enable_i = 1'b0;
      @(negedge clk);
      AcqSig_i = 1'b0;
      Enable_i = 1'b1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b1);
   endtask

   task automatic build_frame(input logic [DATA_BITS-1:0] d, input logic par, input logic stop);
      wave.delete();
      for (int b = 0; b < NB; b++) begin
         logic v;
         if (b == 0) v = 1'b0;
         else if (b <= DATA_BITS) v = d[b-1];
         else if (b == NB - 1) v = stop;
         else v = par;
         for (int t = 0; t < OVERSAMPLE; t++) wave.push_back(v);
      end
   endtask

   task automatic flip(input int b, input int o);
      wave[b*OVERSAMPLE + o] = ~wave[b*OVERSAMPLE + o];
   endtask

   task automatic drive_range(input int from, input int to);
      for (int i = from; i < to; i++) tick(wave[i]);
   endtask

   // Reference: each bit is the majority of the three line samples around
   // its centre; word is LSB-first; stop 0 is a framing error.
   function automatic logic [W-1:0] model_from_wave();
      logic [DATA_BITS-1:0] d;
      logic bv[NB];
      logic perr;
      for (int b = 0; b < NB; b++) begin
         int ones;
         ones = int'(wave[b*OVERSAMPLE + M - 1]) + int'(wave[b*OVERSAMPLE + M])
              + int'(wave[b*OVERSAMPLE + M + 1]);
         bv[b] = (ones >= 2);
      end
      for (int i = 0; i < DATA_BITS; i++) d[i] = bv[i+1];
      perr = 1'b0;
      if (PAR_BITS == 1) perr = ((^d) ^ bv[DATA_BITS+1]) != 1'(PARITY_ODD);
      return {perr, ~bv[NB-1], d};
   endfunction

   task automatic check_frame(input string name, input int synch_before);
      logic [W-1:0] e, g;
      e = exp_q.pop_front();
      check({name, " synch_pulses"}, synch_cnt - synch_before, 1);
      check({name, " valid_pulses"}, got_q.size(), 1);
      if (got_q.size() != 0) begin
         g = got_q.pop_front();
         check({name, " data"}, g[DATA_BITS-1:0], e[DATA_BITS-1:0]);
         check({name, " frame_err"}, g[DATA_BITS], e[DATA_BITS]);
         check({name, " parity_err"}, g[DATA_BITS+1], e[DATA_BITS+1]);
      end
      got_q.delete();
   endtask

   task automatic send_checked(input string name, input logic [DATA_BITS-1:0] d,
                               input logic par, input logic stop);
      int sb;
      build_frame(d, par, stop);
      exp_q.push_back({1'b0, ~stop, d} | ((PAR_BITS == 1 && (((^d) ^ par) != 1'(PARITY_ODD)))
                                          ? {1'b1, {(W-1){1'b0}}} : '0));
      sb = synch_cnt;
      drive_range(0, wave.size());
      idle(SYNC_STAGES + 4);
      check_frame(name, sb);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      string                name;
      logic [DATA_BITS-1:0] data;
      logic                 par;
      logic                 stop;
      bit                   noise;
      logic [DATA_BITS-1:0] exp_data;
      logic                 exp_ferr;
      logic                 exp_perr;
   } vec_t;

   vec_t vecs[$];

   initial begin
      int sb;
      logic [DATA_BITS-1:0] last_data;
      logic last_ferr;

      vecs.push_back('{"valid_a5",  8'hA5, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0});
      vecs.push_back('{"noise_3c",  8'h3C, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0});
      vecs.push_back('{"all_zero",  8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0});
      vecs.push_back('{"all_ones",  8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0});
`ifdef RX_PARITY_CHECK_EN
      vecs.push_back('{"par_bad_01", 8'h01, 1'b0, 1'b1, 1'b0, 8'h01, 1'b0, 1'b1});
      vecs.push_back('{"par_ok_01",  8'h01, 1'b1, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0});
`endif
      vecs.push_back('{"frame_err_5a", 8'h5A, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b0});

      // Reset values while reset is held.
      repeat (3) @(negedge clk);
      check("reset data", frame.Data_o, 0);
      check("reset valid", frame.DataValid_o, 0);
      check("reset frame_err", frame.FrameErr_o, 0);
      check("reset parity_err", frame.ParityErr_o, 0);
      check("reset synch", Rx_Synch_o, 0);
      check("reset state", State_o, ST_IDLE);
      rst = 1'b1;
      Enable_i = 1'b1;
      idle(SYNC_STAGES + 4);
      check("no false edge after reset", synch_cnt, 0);

      // Table-driven frames.
      for (int v = 0; v < vecs.size(); v++) begin
         build_frame(vecs[v].data, vecs[v].par, vecs[v].stop);
         if (vecs[v].noise)
            for (int b = 1; b <= DATA_BITS; b++) flip(b, M);
         exp_q.push_back({vecs[v].exp_perr, vecs[v].exp_ferr, vecs[v].exp_data});
         sb = synch_cnt;
         drive_range(0, wave.size());
         idle(SYNC_STAGES + 4);
         check_frame(vecs[v].name, sb);
      end
      last_data = vecs[vecs.size()-1].exp_data;
      last_ferr = vecs[vecs.size()-1].exp_ferr;

      // Glitch: 3 low ticks is a false start.
      sb = synch_cnt;
      tick(1'b0); tick(1'b0); tick(1'b0);
      idle(2 * OVERSAMPLE);
      check("glitch synch_pulses", synch_cnt - sb, 1);
      check("glitch valid_pulses", got_q.size(), 0);
      check("glitch state", State_o, ST_IDLE);
      check("glitch holds data", frame.Data_o, last_data);
      check("glitch holds frame_err", frame.FrameErr_o, last_ferr);
      got_q.delete();

      // Enable dropped on the stop-vote clk: no DataValid_o.
      build_frame(8'h77, 1'b0, 1'b1);
      synch_tick = -1;
      drop_armed = 1'b1;
      drive_range(0, wave.size());
      idle(SYNC_STAGES + 4);
      drop_armed = 1'b0;
      check("enable_at_stop valid_pulses", got_q.size(), 0);
      check("enable_at_stop state", State_o, ST_IDLE);
      check("enable_at_stop holds data", frame.Data_o, last_data);
      got_q.delete();
      send_checked("after_enable_stop_81", 8'h81, 1'b0, 1'b1);

      // Enable low during data bit 4.
      build_frame(8'h81, 1'b0, 1'b1);
      drive_range(0, 5 * OVERSAMPLE + M);
      check("enable_abort busy", State_o, ST_DATA);
      @(negedge clk);
      Enable_i = 1'b0;
      repeat (2) @(negedge clk);
      check("enable_abort state", State_o, ST_IDLE);
      Enable_i = 1'b1;
      idle(OVERSAMPLE);
      check("enable_abort valid_pulses", got_q.size(), 0);
      check("enable_abort holds data", frame.Data_o, 8'h81);
      got_q.delete();
      send_checked("after_enable_abort_81", 8'h81, 1'b0, 1'b1);

      // Asynchronous reset during data bit 4.
      build_frame(8'h3C, 1'b0, 1'b1);
      drive_range(0, 5 * OVERSAMPLE + M);
      #2 rst = 1'b0;
      #1;
      check("rst_abort state", State_o, ST_IDLE);
      check("rst_abort data", frame.Data_o, 0);
      check("rst_abort valid", frame.DataValid_o, 0);
      @(negedge clk);
      rst = 1'b1;
      idle(OVERSAMPLE);
      check("rst_abort valid_pulses", got_q.size(), 0);
      got_q.delete();
      send_checked("after_rst_abort_81", 8'h81, 1'b0, 1'b1);

      // Randomised noisy frames against the waveform model.
      for (int n = 0; n < 40; n++) begin
         logic [DATA_BITS-1:0] d;
         d = DATA_BITS'($urandom);
         build_frame(d, 1'($urandom), ($urandom_range(0, 4) != 0));
         for (int b = 1; b < NB; b++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 4) begin
               flip(b, M - 1 + $urandom_range(0, 2));
            end else if (r == 4) begin
               int o;
               o = $urandom_range(0, 1);
               flip(b, M - 1 + o);
               flip(b, M + o);
            end
         end
         exp_q.push_back(model_from_wave());
         sb = synch_cnt;
         drive_range(0, wave.size());
         idle($urandom_range(SYNC_STAGES + 2, SYNC_STAGES + 8));
         check_frame($sformatf("random_%0d", n), sb);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
